// File: rtl/ladder_init_xz_pkg.sv
// Shared SM2 curve constants and the ladder-seed FSM state encoding.
package ladder_init_xz_pkg;

    localparam logic [255:0] Sm2P =
        256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
    localparam logic [255:0] Sm2A = Sm2P - 256'd3;
    localparam logic [255:0] Sm2B =
        256'h28E9FA9E_9D9F5E34_4D5A9E4B_CF6509A7_F39789F5_15AB8F92_DDBCBD41_4D940E93;
    localparam logic [255:0] Sm2Gx =
        256'h32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7;

    typedef enum logic [2:0] {
        StIdle, StSq, StSq2, StCube, StBx, StDbl, StFin
    } state_e;

endpackage

// File: rtl/add_mod.sv
// Combinational modular adder; both operands must already be in [0, P-1].
module add_mod #(
    parameter logic [255:0] P = 256'd17
) (
    input  logic [255:0] a_i,
    input  logic [255:0] b_i,
    output logic [255:0] s_o
);
    logic [256:0] sum;
    logic [256:0] red;

    always_comb begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        red = sum - {1'b0, P};
        s_o = (sum >= {1'b0, P}) ? red[255:0] : sum[255:0];
    end
endmodule

// File: rtl/mul_mod_p.sv
// Bit-serial MSB-first modular multiplier; releasing rst_ni launches a product,
// done_o rises 256 clocks later and holds until the next reset.
module mul_mod_p #(
    parameter logic [255:0] P = 256'd17
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [255:0] a_i,
    input  logic [255:0] b_i,
    output logic [255:0] p_o,
    output logic         done_o
);
    logic [255:0] acc_q, acc_d;
    logic [8:0]   cnt_q;
    logic [7:0]   bit_idx;
    logic [256:0] dbl, dbl_r, ad, ad_r;

    always_comb begin
        bit_idx = ~cnt_q[7:0];
        dbl     = {acc_q, 1'b0};
        dbl_r   = (dbl >= {1'b0, P}) ? (dbl - {1'b0, P}) : dbl;
        ad      = {1'b0, dbl_r[255:0]} + {1'b0, a_i};
        ad_r    = (ad >= {1'b0, P}) ? (ad - {1'b0, P}) : ad;
        acc_d   = b_i[bit_idx] ? ad_r[255:0] : dbl_r[255:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (!cnt_q[8]) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 9'd1;
        end
    end

    assign p_o    = acc_q;
    assign done_o = cnt_q[8];
endmodule

// File: rtl/sub_mod.sv
// Combinational modular subtractor; both operands must already be in [0, P-1].
module sub_mod #(
    parameter logic [255:0] P = 256'd17
) (
    input  logic [255:0] a_i,
    input  logic [255:0] b_i,
    output logic [255:0] d_o
);
    // Wrap-around 256-bit arithmetic lands back in range when a < b.
    always_comb d_o = (a_i >= b_i) ? (a_i - b_i) : (a_i - b_i + P);
endmodule

// File: rtl/ladder_init_xz.sv
// Montgomery-ladder seed: (X1:Z1) = (Gx:1) and the x-only projective double (X2:Z2),
// computed with one sequential modular multiplier and combinational add/sub units.
module ladder_init_xz
    import ladder_init_xz_pkg::*;
#(
    parameter logic [255:0] P = Sm2P,
    parameter logic [255:0] A = Sm2A,
    parameter logic [255:0] B = Sm2B
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [255:0] gx_i,
    output logic [255:0] x1_o,
    output logic [255:0] z1_o,
    output logic [255:0] x2_o,
    output logic [255:0] z2_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic         inf_o
);
    state_e       state_q;
    logic [1:0]   dbl_cnt_q;
    logic         mul_run_q, mul_done;
    logic [255:0] x_q, t_q, u_q, v_q, w_q;
    logic [255:0] x1_q, z1_q, x2_q, z2_q;
    logic         busy_q, done_q, err_q, inf_q;
    logic [255:0] mul_a, mul_b, mul_p;
    logic [255:0] add_a_a, add_a_b, add_a_s, add_b_s, sub_a, sub_b, sub_d;

    always_comb begin
        add_a_a = v_q;
        add_a_b = v_q;
        if (state_q == StCube) begin
            add_a_a = t_q;
            add_a_b = A;
        end else if (state_q == StDbl && dbl_cnt_q == 2'd0) begin
            add_a_b = B;
        end
        sub_a = (state_q == StFin) ? u_q : t_q;
        sub_b = (state_q == StFin) ? w_q : A;
        mul_a = x_q;
        mul_b = x_q;
        case (state_q)
            StSq2:   begin mul_a = sub_d;   mul_b = sub_d; end
            StCube:  begin mul_a = add_a_s; mul_b = x_q;   end
            StBx:    begin mul_a = B;       mul_b = x_q;   end
            default: ;
        endcase
    end

    add_mod #(.P(P)) u_add_a (.a_i(add_a_a), .b_i(add_a_b), .s_o(add_a_s));
    add_mod #(.P(P)) u_add_b (.a_i(w_q), .b_i(w_q), .s_o(add_b_s));
    sub_mod #(.P(P)) u_sub (.a_i(sub_a), .b_i(sub_b), .d_o(sub_d));
    mul_mod_p #(.P(P)) u_mul (
        .clk_i  (clk_i),
        .rst_ni (mul_run_q),
        .a_i    (mul_a),
        .b_i    (mul_b),
        .p_o    (mul_p),
        .done_o (mul_done)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            dbl_cnt_q <= '0;
            mul_run_q <= 1'b0;
            {x_q, t_q, u_q, v_q, w_q}    <= '0;
            {x1_q, z1_q, x2_q, z2_q}     <= '0;
            {busy_q, done_q, err_q, inf_q} <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: if (start_i) begin
                    err_q <= 1'b0;
                    inf_q <= 1'b0;
                    if (gx_i >= P) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        {x1_q, z1_q, x2_q, z2_q} <= '0;
                    end else begin
                        x_q     <= gx_i;
                        busy_q  <= 1'b1;
                        state_q <= StSq;
                    end
                end
                StSq, StSq2, StCube, StBx: begin
                    // First cycle launches the multiplier; its done retires the state.
                    if (!mul_run_q) begin
                        mul_run_q <= 1'b1;
                    end else if (mul_done) begin
                        mul_run_q <= 1'b0;
                        case (state_q)
                            StSq:    begin t_q <= mul_p; state_q <= StSq2; end
                            StSq2:   begin u_q <= mul_p; state_q <= StCube; end
                            StCube:  begin v_q <= mul_p; state_q <= StBx; end
                            default: begin w_q <= mul_p; state_q <= StDbl; end
                        endcase
                    end
                end
                StDbl: begin
                    v_q       <= add_a_s;
                    w_q       <= add_b_s;
                    dbl_cnt_q <= dbl_cnt_q + 2'd1;
                    if (dbl_cnt_q == 2'd2) begin
                        dbl_cnt_q <= '0;
                        state_q   <= StFin;
                    end
                end
                StFin: begin
                    x1_q    <= x_q;
                    z1_q    <= 256'd1;
                    x2_q    <= sub_d;
                    z2_q    <= v_q;
                    inf_q   <= (v_q == '0);
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign x1_o   = x1_q;
    assign z1_o   = z1_q;
    assign x2_o   = x2_q;
    assign z2_o   = z2_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;
    assign inf_o  = inf_q;
endmodule

// File: tb/tb_ladder_init_xz.sv
// Bench for ladder_init_xz: three parameterisations driven in lockstep and checked
// against a wide-integer evaluation of the seed formulas.
module tb_ladder_init_xz;
    import ladder_init_xz_pkg::*;

    localparam int NDut = 3;
    // Edges from the accepting edge (counted as 1) to done: 4 multiplies of 258 + 5.
    localparam int RunLat = 4 * 258 + 5;
    localparam int ErrLat = 1;

    typedef logic [1023:0] wide_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [255:0] gx = '0;
    logic [255:0] x1 [NDut];
    logic [255:0] z1 [NDut];
    logic [255:0] x2 [NDut];
    logic [255:0] z2 [NDut];
    logic         busy [NDut];
    logic         done [NDut];
    logic         err [NDut];
    logic         inf [NDut];
    logic [255:0] mp [NDut];
    logic [255:0] ma [NDut];
    logic [255:0] mb [NDut];

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    ladder_init_xz #(.P(256'd17), .A(256'd2), .B(256'd2)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .gx_i(gx),
        .x1_o(x1[0]), .z1_o(z1[0]), .x2_o(x2[0]), .z2_o(z2[0]),
        .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]), .inf_o(inf[0])
    );
    // b chosen so that x=1 is a root of x^3+ax+b, making 2G the point at infinity.
    ladder_init_xz #(.P(256'd17), .A(256'd2), .B(256'd14)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .gx_i(gx),
        .x1_o(x1[1]), .z1_o(z1[1]), .x2_o(x2[1]), .z2_o(z2[1]),
        .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]), .inf_o(inf[1])
    );
    ladder_init_xz u_dut_sm2 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .gx_i(gx),
        .x1_o(x1[2]), .z1_o(z1[2]), .x2_o(x2[2]), .z2_o(z2[2]),
        .busy_o(busy[2]), .done_o(done[2]), .err_o(err[2]), .inf_o(inf[2])
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input int i, input logic [255:0] g,
                         output logic [255:0] ex2, output logic [255:0] ez2,
                         output logic eerr);
        wide_t p, a, b, x, q, r;
        p = wide_t'(mp[i]);
        a = wide_t'(ma[i]);
        b = wide_t'(mb[i]);
        x = wide_t'(g);
        eerr = (g >= mp[i]);
        q = (x * x) % p;
        q = (q + p - a) % p;
        q = (q * q) % p;
        r = (8 * b * x) % p;
        ex2 = 256'((q + p - r) % p);
        ez2 = 256'((4 * (((x * x) % p) * x + a * x + b)) % p);
        if (eerr) begin
            ex2 = '0;
            ez2 = '0;
        end
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < NDut; i++) begin
            chk($sformatf("%s_d%0d_x1", tag, i), x1[i], '0);
            chk($sformatf("%s_d%0d_z1", tag, i), z1[i], '0);
            chk($sformatf("%s_d%0d_x2", tag, i), x2[i], '0);
            chk($sformatf("%s_d%0d_z2", tag, i), z2[i], '0);
            chk($sformatf("%s_d%0d_flags", tag, i),
                {252'd0, busy[i], done[i], err[i], inf[i]}, '0);
        end
    endtask

    // Releases reset and issues start on the same edge, then watches every DUT.
    task automatic do_run(input string tag, input logic [255:0] g, input bit hold,
                          input logic [255:0] g_late);
        logic [255:0] ex2 [NDut];
        logic [255:0] ez2 [NDut];
        logic         eerr [NDut];
        int           first [NDut];
        int           ndone [NDut];
        for (int i = 0; i < NDut; i++) begin
            model(i, g, ex2[i], ez2[i], eerr[i]);
            first[i] = 0;
            ndone[i] = 0;
        end
        @(negedge clk);
        rst = 1'b0;
        gx = g;
        start = 1'b1;
        for (int c = 1; c <= RunLat + 3; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (c == 4) gx = g_late;
            for (int i = 0; i < NDut; i++) begin
                if (c == 1 && !eerr[i]) begin
                    chk($sformatf("%s_d%0d_busy", tag, i), 256'(busy[i]), 256'd1);
                    chk($sformatf("%s_d%0d_errclr", tag, i), 256'(err[i]), 256'd0);
                end
                if (done[i]) begin
                    ndone[i]++;
                    if (first[i] == 0) first[i] = c;
                    chk($sformatf("%s_d%0d_x1", tag, i), x1[i], eerr[i] ? '0 : g);
                    chk($sformatf("%s_d%0d_z1", tag, i), z1[i], eerr[i] ? '0 : 256'd1);
                    chk($sformatf("%s_d%0d_x2", tag, i), x2[i], ex2[i]);
                    chk($sformatf("%s_d%0d_z2", tag, i), z2[i], ez2[i]);
                    chk($sformatf("%s_d%0d_err", tag, i), 256'(err[i]), 256'(eerr[i]));
                    chk($sformatf("%s_d%0d_inf", tag, i), 256'(inf[i]),
                        256'(!eerr[i] && ez2[i] == '0));
                    if (hold) start = 1'b0;
                end
            end
        end
        start = 1'b0;
        for (int i = 0; i < NDut; i++) begin
            chk($sformatf("%s_d%0d_lat", tag, i), 256'(first[i]),
                256'(eerr[i] ? ErrLat : RunLat));
            chk($sformatf("%s_d%0d_ndone", tag, i), 256'(ndone[i]), 256'd1);
            chk($sformatf("%s_d%0d_idle", tag, i), 256'(busy[i]), 256'd0);
            chk($sformatf("%s_d%0d_hold_x2", tag, i), x2[i], ex2[i]);
            chk($sformatf("%s_d%0d_hold_z2", tag, i), z2[i], ez2[i]);
        end
    endtask

    initial begin
        logic [255:0] g;
        mp[0] = 256'd17; ma[0] = 256'd2; mb[0] = 256'd2;
        mp[1] = 256'd17; ma[1] = 256'd2; mb[1] = 256'd14;
        mp[2] = Sm2P;    ma[2] = Sm2A;   mb[2] = Sm2B;

        repeat (3) @(negedge clk);
        chk_zero("reset");

        do_run("gx5", 256'd5, 1'b0, 256'd5);
        chk("gx5_const_x2", x2[0], 256'd7);
        chk("gx5_const_z2", z2[0], 256'd4);
        do_run("gx0", 256'd0, 1'b0, 256'd0);
        chk("gx0_const_x2", x2[0], 256'd4);
        chk("gx0_const_z2", z2[0], 256'd8);
        do_run("gx17", 256'd17, 1'b0, 256'd17);
        do_run("sm2gx", Sm2Gx, 1'b0, Sm2Gx);
        do_run("allones", '1, 1'b0, '1);
        do_run("gx16", 256'd16, 1'b0, 256'd16);
        do_run("inf", 256'd1, 1'b0, 256'd1);
        do_run("hold", 256'd5, 1'b1, 256'd9);

        // Abort mid-run (inside the third multiply) with reset.
        @(negedge clk);
        gx = 256'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (600) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("abort");
        do_run("post_abort", 256'd5, 1'b0, 256'd5);
        chk("post_abort_const_x2", x2[0], 256'd7);

        for (int k = 0; k < 14; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                g = 256'($urandom_range(0, 20));
            end else begin
                for (int j = 0; j < 8; j++) g[j*32 +: 32] = $urandom;
            end
            do_run($sformatf("rnd%0d", k), g, 1'b0, ~g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
